// File: rtl/shift_pipe_pkg.sv
// Shared types and helpers for the shift_pipe barrel shifter.
// Provides the operation encoding and the width/stage-count helpers used by
// the top and by every pipeline stage.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_e;

  localparam int OP_W = 2;

  // Number of barrel mux levels needed for a WIDTH-bit operand.
  function automatic int log2w(input int width);
    return $clog2(width);
  endfunction

  // Pipeline depth for a given width and mux levels per stage.
  function automatic int num_stages(input int width, input int lvl_per_stg);
    return (log2w(width) + lvl_per_stg - 1) / lvl_per_stg;
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One pipeline stage of shift_pipe: NUM_LVL right-shift mux levels starting
// at level FIRST_LVL, followed by the stage register and its flow control.
// Optional rotate support is compiled in with SHIFT_PIPE_ROR_EN.
//
// Handshake: the stage takes a new entry from upstream whenever it is empty
// or its current entry leaves this cycle (down_free says the downstream slot
// can absorb it). Upstream's "valid" is up_valid; the stage's occupancy is
// exposed on valid.
module shift_pipe_stage
  import shift_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TAG_W     = 4,
  parameter int LOG2W     = 5,
  parameter int FIRST_LVL = 0,
  parameter int NUM_LVL   = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             down_free,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic [LOG2W-1:0] up_amt,
  input  shift_op_e        up_op,
  input  logic             up_fill,
  input  logic             up_sat,
  input  logic [TAG_W-1:0] up_tag,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [LOG2W-1:0] amt,
  output shift_op_e        op,
  output logic             fill,
  output logic             sat,
  output logic [TAG_W-1:0] tag
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [LOG2W-1:0] amt;
    shift_op_e        op;
    logic             fill;
    logic             sat;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t           stage_q;
  stage_t           stage_d;
  logic [WIDTH-1:0] shifted;
  logic             take;

`ifdef SHIFT_PIPE_ROR_EN
  logic is_ror;
  assign is_ror = (up_op == SHIFT_ROR);
`endif

  assign take = !stage_q.valid || down_free;

  // Saturation (first stage only) then this stage's shift levels.
  always_comb begin : shift_levels
    int sh;
    shifted = up_data;
    sh      = 0;
    // A saturated non-rotate shift collapses to the fill pattern; further
    // levels keep inserting the same fill so the pattern survives the pipe.
`ifdef SHIFT_PIPE_ROR_EN
    if (FIRST_LVL == 0 && up_sat && !is_ror) shifted = {WIDTH{up_fill}};
`else
    if (FIRST_LVL == 0 && up_sat) shifted = {WIDTH{up_fill}};
`endif
    for (int k = 0; k < NUM_LVL; k++) begin
      sh = 1 << (FIRST_LVL + k);
      if (up_amt[FIRST_LVL + k]) begin
`ifdef SHIFT_PIPE_ROR_EN
        if (is_ror) begin
          shifted = (shifted >> sh) | (shifted << (WIDTH - sh));
        end else begin
          shifted = (shifted >> sh) | ({WIDTH{up_fill}} & ~({WIDTH{1'b1}} >> sh));
        end
`else
        shifted = (shifted >> sh) | ({WIDTH{up_fill}} & ~({WIDTH{1'b1}} >> sh));
`endif
      end
    end
  end

  // Next register contents: load when the slot frees, otherwise hold.
  always_comb begin
    stage_d = stage_q;
    if (take) begin
      stage_d.valid = up_valid;
      if (up_valid) begin
        stage_d.data = shifted;
        stage_d.amt  = up_amt;
        stage_d.op   = up_op;
        stage_d.fill = up_fill;
        stage_d.sat  = up_sat;
        stage_d.tag  = up_tag;
      end
    end
  end

  // Stage register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign valid = stage_q.valid;
  assign data  = stage_q.data;
  assign amt   = stage_q.amt;
  assign op    = stage_q.op;
  assign fill  = stage_q.fill;
  assign sat   = stage_q.sat;
  assign tag   = stage_q.tag;

endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined WIDTH-bit barrel shifter (SLL/SRL/SRA, optional ROR)
// with valid/ready flow control, per-stage bubble collapse and a result tag.
// Define SHIFT_PIPE_ROR_EN to build rotate-right for op 11; otherwise op 11
// behaves as SRL.
//
// Handshake: an operation is accepted when in_valid && in_ready, and a result
// is consumed when out_valid && out_ready. in_ready depends combinationally
// on out_ready only; out_* come from registers.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int LVL_PER_STG = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_amt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LOG2W  = log2w(WIDTH);
  localparam int STAGES = num_stages(WIDTH, LVL_PER_STG);

  // Index 0 is the decoded input; index s+1 is the register of stage s.
  logic             st_valid [STAGES+1];
  logic [WIDTH-1:0] st_data  [STAGES+1];
  logic [LOG2W-1:0] st_amt   [STAGES+1];
  shift_op_e        st_op    [STAGES+1];
  logic             st_fill  [STAGES+1];
  logic             st_sat   [STAGES+1];
  logic [TAG_W-1:0] st_tag   [STAGES+1];

  logic [STAGES-1:0] free;
  logic [WIDTH-1:0]  a_rev;
  logic [WIDTH-1:0]  last_rev;
  shift_op_e         dec_op;

  assign dec_op = shift_op_e'(in_op);

  // Input decode: fill bit, saturation flag, and operand reversal for SLL.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      a_rev[i] = in_a[WIDTH-1-i];
    end
  end

  assign st_valid[0] = in_valid;
  assign st_data[0]  = (dec_op == SHIFT_SLL) ? a_rev : in_a;
  assign st_amt[0]   = in_amt[LOG2W-1:0];
  assign st_op[0]    = dec_op;
  assign st_fill[0]  = (dec_op == SHIFT_SRA) && in_a[WIDTH-1];
  assign st_sat[0]   = |in_amt[WIDTH-1:LOG2W];
  assign st_tag[0]   = in_tag;

  // Ready chain: stage s may pass its entry on when the next slot is empty
  // or will itself empty this cycle; the last stage drains on out_ready.
  always_comb begin
    free = '0;
    free[STAGES-1] = out_ready;
    for (int s = STAGES - 2; s >= 0; s--) begin
      free[s] = !st_valid[s+2] || free[s+1];
    end
  end

  assign in_ready = !st_valid[1] || free[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int FIRST = s * LVL_PER_STG;
    localparam int NUM   = (LOG2W - FIRST < LVL_PER_STG) ? (LOG2W - FIRST) : LVL_PER_STG;

    shift_pipe_stage #(
      .WIDTH    (WIDTH),
      .TAG_W    (TAG_W),
      .LOG2W    (LOG2W),
      .FIRST_LVL(FIRST),
      .NUM_LVL  (NUM)
    ) u_stage (
      .clock    (clock),
      .reset_n  (reset_n),
      .down_free(free[s]),
      .up_valid (st_valid[s]),
      .up_data  (st_data[s]),
      .up_amt   (st_amt[s]),
      .up_op    (st_op[s]),
      .up_fill  (st_fill[s]),
      .up_sat   (st_sat[s]),
      .up_tag   (st_tag[s]),
      .valid    (st_valid[s+1]),
      .data     (st_data[s+1]),
      .amt      (st_amt[s+1]),
      .op       (st_op[s+1]),
      .fill     (st_fill[s+1]),
      .sat      (st_sat[s+1]),
      .tag      (st_tag[s+1])
    );
  end

  // Output: undo the SLL operand reversal on the last register.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      last_rev[i] = st_data[STAGES][WIDTH-1-i];
    end
  end

  assign out_valid = st_valid[STAGES];
  assign out_data  = (st_op[STAGES] == SHIFT_SLL) ? last_rev : st_data[STAGES];
  assign out_tag   = st_tag[STAGES];

  // Amount/fill/sat of the final register are spent; nothing reads them.
  logic unused_tail;
  assign unused_tail = ^{st_amt[STAGES], st_fill[STAGES], st_sat[STAGES]};

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: a default instance (3 stages) under
// directed, backpressure, reset and random traffic, plus LVL_PER_STG=1 and
// LVL_PER_STG=5 instances fed the same stream with out_ready held high.
module tb_shift_pipe;

  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRL = 2'd1;
  localparam logic [1:0] OP_SRA = 2'd2;
  localparam logic [1:0] OP_ROR = 2'd3;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_amt;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        rdy1, ov1, rdy5, ov5;
  logic [31:0] od1, od5;
  logic [3:0]  ot1, ot5;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_stall = -1;
  logic [31:0] cur_exp;

  logic [31:0] exp_q[$];
  logic [3:0]  tag_q[$];
  int          acc_q[$];
  logic [31:0] e1_q[$];
  logic [3:0]  t1_q[$];
  int          a1_q[$];
  logic [31:0] e5_q[$];
  logic [3:0]  t5_q[$];
  int          a5_q[$];

  shift_pipe #(.WIDTH(32), .LVL_PER_STG(2), .TAG_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_amt(in_amt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  shift_pipe #(.WIDTH(32), .LVL_PER_STG(1), .TAG_W(4)) dut_l1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_op(in_op), .in_a(in_a), .in_amt(in_amt), .in_tag(in_tag),
    .out_valid(ov1), .out_ready(1'b1), .out_data(od1), .out_tag(ot1)
  );

  shift_pipe #(.WIDTH(32), .LVL_PER_STG(5), .TAG_W(4)) dut_l5 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy5),
    .in_op(in_op), .in_a(in_a), .in_amt(in_amt), .in_tag(in_tag),
    .out_valid(ov5), .out_ready(1'b1), .out_data(od5), .out_tag(ot5)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Reference model, written from the operation definitions.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] amt);
    logic sat;
    int   n;
    sat = |amt[31:5];
    n   = int'(amt[4:0]);
    case (op)
      OP_SLL: return sat ? 32'h0 : (a << n);
      OP_SRL: return sat ? 32'h0 : (a >> n);
      OP_SRA: return sat ? {32{a[31]}} : 32'($signed(a) >>> n);
      default: begin
`ifdef SHIFT_PIPE_ROR_EN
        return (n == 0) ? a : ((a >> n) | (a << (32 - n)));
`else
        return sat ? 32'h0 : (a >> n);
`endif
      end
    endcase
  endfunction

  // Scoreboard: push on accept, pop and compare on emit (sampled at negedge).
  always @(negedge clock) begin
    logic [31:0] e;
    logic [3:0]  t;
    int          a;
    cyc++;
    if (!reset_n) begin
      exp_q.delete(); tag_q.delete(); acc_q.delete();
      e1_q.delete();  t1_q.delete();  a1_q.delete();
      e5_q.delete();  t5_q.delete();  a5_q.delete();
    end else begin
      if (!out_ready) last_stall = cyc;
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL main_unexpected_out: got data=%h tag=%0d, required no output", out_data, out_tag);
        end else begin
          e = exp_q.pop_front(); t = tag_q.pop_front(); a = acc_q.pop_front();
          if (out_data !== e || out_tag !== t) begin
            n_fail++;
            $display("FAIL main_result: got data=%h tag=%0d, required data=%h tag=%0d", out_data, out_tag, e, t);
          end
          if (a > last_stall) begin
            n_tests++;
            if (cyc - a !== 3) begin
              n_fail++;
              $display("FAIL main_latency: got %0d cycles, required 3 (tag %0d)", cyc - a, t);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp); tag_q.push_back(in_tag); acc_q.push_back(cyc);
      end
      if (ov1) begin
        n_tests++;
        if (e1_q.size() == 0) begin
          n_fail++;
          $display("FAIL lvl1_unexpected_out: got data=%h, required no output", od1);
        end else begin
          e = e1_q.pop_front(); t = t1_q.pop_front(); a = a1_q.pop_front();
          if (od1 !== e || ot1 !== t || cyc - a !== 5) begin
            n_fail++;
            $display("FAIL lvl1_result: got data=%h tag=%0d lat=%0d, required data=%h tag=%0d lat=5", od1, ot1, cyc - a, e, t);
          end
        end
      end
      if (in_valid && rdy1) begin
        e1_q.push_back(cur_exp); t1_q.push_back(in_tag); a1_q.push_back(cyc);
      end
      if (ov5) begin
        n_tests++;
        if (e5_q.size() == 0) begin
          n_fail++;
          $display("FAIL lvl5_unexpected_out: got data=%h, required no output", od5);
        end else begin
          e = e5_q.pop_front(); t = t5_q.pop_front(); a = a5_q.pop_front();
          if (od5 !== e || ot5 !== t || cyc - a !== 1) begin
            n_fail++;
            $display("FAIL lvl5_result: got data=%h tag=%0d lat=%0d, required data=%h tag=%0d lat=1", od5, ot5, cyc - a, e, t);
          end
        end
      end
      if (in_valid && rdy5) begin
        e5_q.push_back(cur_exp); t5_q.push_back(in_tag); a5_q.push_back(cyc);
      end
    end
  end

  // Driver: offer one op until the main instance accepts it (bounded).
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] amt,
                      input logic [3:0] tag, input logic [31:0] exp);
    in_op = op; in_a = a; in_amt = amt; in_tag = tag; cur_exp = exp;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_tests++; n_fail++;
    $display("FAIL send_timeout: tag %0d in_ready=%b, required 1 within 100 cycles", tag, in_ready);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_q.size() != 0 || e1_q.size() != 0 || e5_q.size() != 0) && i < 300) begin
      @(negedge clock);
      i++;
    end
    n_tests++;
    if (exp_q.size() != 0 || e1_q.size() != 0 || e5_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending main=%0d l1=%0d l5=%0d, required 0", exp_q.size(), e1_q.size(), e5_q.size());
    end
  endtask

  task automatic test_reset();
    int seen;
    reset_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_op = OP_SRL; in_a = 32'hFFFF_FFFF; in_amt = 32'd1; in_tag = 4'd9;
    cur_exp = 32'hDEAD_BEEF;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clock);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_tests++;
    if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
    n_tests++;
    if (out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_out_tag: got %h, required 0", out_tag); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL reset_no_accept: got %0d output cycles, required 0", seen); end
  endtask

  task automatic test_directed();
    @(posedge clock); #1;
    send(OP_SRA, 32'h8000_0000, 32'd4,          4'd0, 32'hF800_0000);
    send(OP_SRL, 32'h8000_0000, 32'd4,          4'd1, 32'h0800_0000);
    send(OP_SLL, 32'h0000_0001, 32'd31,         4'd2, 32'h8000_0000);
    send(OP_SLL, 32'hFFFF_FFFF, 32'd0,          4'd3, 32'hFFFF_FFFF);
    send(OP_SRA, 32'h8000_0001, 32'h20,         4'd4, 32'hFFFF_FFFF);
    send(OP_SRL, 32'h8000_0001, 32'h20,         4'd5, 32'h0000_0000);
    send(OP_SLL, 32'hFFFF_FFFF, 32'hFFFF_FFE1,  4'd6, 32'h0000_0000);
    send(OP_SRA, 32'h7FFF_FFFF, 32'd31,         4'd7, 32'h0000_0000);
`ifdef SHIFT_PIPE_ROR_EN
    send(OP_ROR, 32'h0000_0001, 32'd33,         4'd8, 32'h8000_0000);
    send(OP_ROR, 32'h1234_5678, 32'd4,          4'd9, 32'h8123_4567);
`else
    send(OP_ROR, 32'h0000_0001, 32'd33,         4'd8, 32'h0000_0000);
    send(OP_ROR, 32'h1234_5678, 32'd4,          4'd9, 32'h0123_4567);
`endif
    drain();
  endtask

  task automatic test_back_to_back();
    time t0;
    @(posedge clock); #1;
    t0 = $time;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, amt;
      logic [1:0]  op;
      a = $urandom; amt = $urandom_range(0, 31); op = 2'($urandom_range(0, 3));
      send(op, a, amt, 4'(i), model(op, a, amt));
    end
    n_tests++;
    if ($time - t0 != 160) begin
      n_fail++;
      $display("FAIL back_to_back_rate: got %0t for 16 ops, required 160", $time - t0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] held_d;
    logic [3:0]  held_t;
    @(posedge clock); #1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [31:0] a, amt;
          logic [1:0]  op;
          a = $urandom; amt = $urandom_range(0, 31); op = 2'($urandom_range(0, 2));
          send(op, a, amt, 4'(i), model(op, a, amt));
        end
      end
      begin
        repeat (4) @(posedge clock);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
          @(negedge clock);
          n_tests++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_full: cycle %0d in_ready=%b out_valid=%b, required 0/1", c + 4, in_ready, out_valid);
          end
          if (c == 0) begin
            held_d = out_data; held_t = out_tag;
            n_tests++;
            if (out_tag !== 4'd1) begin n_fail++; $display("FAIL stall_head_tag: got %0d, required 1", out_tag); end
          end else begin
            n_tests++;
            if (out_data !== held_d || out_tag !== held_t) begin
              n_fail++;
              $display("FAIL stall_hold: got %h/%0d, required %h/%0d", out_data, out_tag, held_d, held_t);
            end
          end
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(negedge clock);
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b, required 1", in_ready); end
      end
    join
    drain();
  endtask

  task automatic test_reset_flush();
    int seen;
    @(posedge clock); #1;
    send(OP_SRL, 32'hF0F0_F0F0, 32'd4, 4'd10, 32'h0F0F_0F0F);
    send(OP_SLL, 32'h0000_00FF, 32'd8, 4'd11, 32'h0000_FF00);
    reset_n = 1'b0;
    in_valid = 1'b1; in_op = OP_SRL; in_a = 32'h1; in_amt = 32'd0; in_tag = 4'd12; cur_exp = 32'h1;
    @(posedge clock);
    #1 reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clock);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL flush_discard: got %0d output cycles, required 0", seen); end
    @(posedge clock); #1;
    send(OP_SRA, 32'h8000_0000, 32'd4, 4'd13, 32'hF800_0000);
    drain();
  endtask

  task automatic test_random();
    logic done;
    done = 1'b0;
    @(posedge clock); #1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [31:0] a, amt;
          logic [1:0]  op;
          a   = $urandom;
          amt = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 31));
          op  = 2'($urandom_range(0, 3));
          send(op, a, amt, 4'(i), model(op, a, amt));
        end
        done = 1'b1;
      end
      begin
        for (int i = 0; i < 5000 && !done; i++) begin
          @(posedge clock);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_amt = '0; in_tag = '0;
    out_ready = 1'b1; cur_exp = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
